plru_alloc_ctrl: RTL
====================

# plru_alloc_ctrl

Entry allocator for small fully associative structures such as TLBs and victim buffers. It owns the per-entry valid bits and the pseudo-LRU tree state. It answers allocation requests with a victim index over a valid/ready handshake, and takes hit and invalidate notifications from the lookup side. It sits beside the tag array and consumes usage information. It produces replacement decisions: the lowest-index invalid entry if one exists, otherwise the PLRU victim.

## Interface
- ENTRIES, 16, number of entries; power of two, ≥2
- IdxW, $clog2(ENTRIES), derived; not to be overridden
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; **one clock; reset is synchronous and active-low**
- flush_i  in  1  clear all valid bits and the tree
- hit_valid_i  in  1  lookup hit this cycle
- hit_idx_i  in  IdxW  index of the hit entry
- inval_valid_i  in  1  invalidate one entry
- inval_idx_i  in  IdxW  entry to invalidate
- alloc_req_valid_i  in  1  allocation request
- alloc_req_ready_o  out  1  request accepted when high with valid
- alloc_rsp_valid_o  out  1  response holds a victim
- alloc_rsp_ready_i  in  1  consumer takes the response
- alloc_rsp_idx_o  out  IdxW  allocated entry
- alloc_rsp_evict_o  out  1  the allocated entry was valid before allocation (eviction)
- valid_o  out  ENTRIES  per-entry valid bits

## Operation
- The tree has ENTRIES-1 node bits, heap-indexed: root is node 0, and node n has children 2n+1 and 2n+2. Level l uses index bit IdxW-1-l.
- **Touch i:** every node on the path of i is set to the inverse of i's bit at that level, so the path points away from i.
- **Victim:** start at the root and follow the node values (0 = lower half, 1 = upper half) to a leaf.
- **Selection:** if any valid bit is 0, pick the lowest-index invalid entry with evict=0. Otherwise pick the PLRU victim with evict=1.
- FSM states: IDLE and RESP.
  - IDLE: alloc_req_ready_o = !flush_i. On acceptance, latch the index and evict flag, set valid[idx], touch idx, and go to RESP.
  - RESP: alloc_rsp_valid_o = 1 and alloc_req_ready_o = 0. Return to IDLE on alloc_rsp_ready_i.
- **Hit:** touches hit_idx_i. It is ignored for tree update if an allocation is accepted in the same cycle, because the allocation touch wins. Hits never change valid bits.
- **Invalidate:** clears valid[inval_idx_i]. If an allocation of the same index is accepted in the same cycle, the allocation wins and the entry stays valid.
- **Flush:** clears all valid bits and all tree bits. It overrides hit, invalidate and acceptance in that cycle.
- **Flush in RESP:** the pending response is kept and completes normally. Its entry's valid bit is still cleared.

## Timing
- Reset values: state IDLE, tree 0, valid_o=0, alloc_rsp_valid_o=0, alloc_rsp_idx_o=0, alloc_rsp_evict_o=0.
- alloc_req_ready_o is 1 in the first cycle after reset release.
- alloc_rsp_valid_o rises the cycle after acceptance.
- valid_o and the tree reflect accept, hit, invalidate and flush one cycle after the event.
- Victim selection uses the valid/tree state registered before the acceptance edge. Same-cycle hit and invalidate events do not affect the decision.
- Response fields are stable while valid && !ready.
- Throughput is at most one allocation per two cycles; there is no accept in RESP.
- Reset asserted mid-operation drops any pending response. All outputs return to their reset values on the next edge.

## Structure
- Package plru_alloc_pkg: state enum (IDLE, RESP) and an idx_width function.
- Sub-module plru_alloc_decode: purely combinational. It takes the tree and valid bits and produces the victim index, the evict flag, and the per-index touch masks.
- The top level holds all registers: tree, valid bits, FSM and response.

## Test plan
All scenarios use ENTRIES=4 and alloc_rsp_ready_i=1 unless stated.
- **Fill:** after reset, four back-to-back allocations → idx 0,1,2,3, all evict=0; valid_o=4'b1111.
- **Full:** a fifth allocation → idx 0, evict=1 (tree after touches 0..3: root=0, node1=0).
- **Hit:** hit idx 0 for one cycle, then allocate → idx 2, evict=1.
- **Backpressure:** hold alloc_rsp_ready_i=0 for 3 cycles → rsp_valid stays 1 with idx and evict stable, and req_ready=0; ready=1 → back to IDLE next cycle.
- **Invalidate:** invalidate idx 1, then allocate → idx 1, evict=0.
- **Collision and flush:**
  - Invalidate idx 3 in the same cycle as allocation of idx 3 is accepted → valid[3]=1.
  - Flush during RESP → valid_o=0 next cycle and the response is still delivered.
  - A following allocation → idx 0, evict=0.

Source files
------------

// File: rtl/plru_alloc_pkg.sv
// Shared types and helpers for the PLRU entry allocator.
// Holds the handshake FSM encoding and the index-width helper.
package plru_alloc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Width of an entry index; a single-entry structure still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plru_alloc_decode.sv
// Combinational replacement decode: victim choice, eviction flag and the
// per-index tree update masks used for touches.
module plru_alloc_decode
    import plru_alloc_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IdxW = idx_width(ENTRIES),
    localparam int TreeW = ENTRIES - 1
) (
    input  logic [TreeW-1:0]                tree,
    input  logic [ENTRIES-1:0]              valid,
    output logic [IdxW-1:0]                 victim_idx,
    output logic                            evict,
    output logic [ENTRIES-1:0][TreeW-1:0]   touch_mask,
    output logic [ENTRIES-1:0][TreeW-1:0]   touch_val
);

    logic [IdxW-1:0] free_idx;
    logic [IdxW-1:0] plru_idx;

    // Scanning downward leaves the lowest invalid index as the final winner.
    always_comb begin : free_search
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (((valid >> i) & ENTRIES'(1)) == '0) begin
                free_idx = IdxW'(i);
            end
        end
    end

    always_comb begin : plru_walk
        int node;
        logic dir;
        node     = 0;
        dir      = 1'b0;
        plru_idx = '0;
        for (int l = 0; l < IdxW; l++) begin
            dir      = ((tree >> node) & TreeW'(1)) != '0;
            plru_idx = (plru_idx << 1) | IdxW'(dir);
            node     = dir ? (2 * node + 2) : (2 * node + 1);
        end
    end

    assign evict      = &valid;
    assign victim_idx = evict ? plru_idx : free_idx;

    // Node visited at level l by index i is (2^l - 1) + (top l bits of i).
    for (genvar i = 0; i < ENTRIES; i++) begin : g_touch
        logic [TreeW-1:0] mask;
        logic [TreeW-1:0] val;

        always_comb begin
            mask = '0;
            val  = '0;
            for (int l = 0; l < IdxW; l++) begin
                mask = mask | (TreeW'(1) << ((1 << l) - 1 + (i >> (IdxW - l))));
                if (((i >> (IdxW - 1 - l)) & 1) == 0) begin
                    val = val | (TreeW'(1) << ((1 << l) - 1 + (i >> (IdxW - l))));
                end
            end
        end

        assign touch_mask[i] = mask;
        assign touch_val[i]  = val;
    end

endmodule

// File: rtl/plru_alloc_ctrl.sv
// Entry allocator: owns valid bits and the PLRU tree, answers allocation
// requests over a valid/ready handshake and absorbs hit/invalidate/flush.
module plru_alloc_ctrl
    import plru_alloc_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IdxW = idx_width(ENTRIES)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                hit_valid_i,
    input  logic [IdxW-1:0]     hit_idx_i,
    input  logic                inval_valid_i,
    input  logic [IdxW-1:0]     inval_idx_i,
    input  logic                alloc_req_valid_i,
    output logic                alloc_req_ready_o,
    output logic                alloc_rsp_valid_o,
    input  logic                alloc_rsp_ready_i,
    output logic [IdxW-1:0]     alloc_rsp_idx_o,
    output logic                alloc_rsp_evict_o,
    output logic [ENTRIES-1:0]  valid_o
);

    localparam int TreeW = ENTRIES - 1;

    state_e                        state_q, state_d;
    logic [TreeW-1:0]              tree_q, tree_d;
    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [IdxW-1:0]               rsp_idx_q;
    logic                          rsp_evict_q;

    logic [IdxW-1:0]               victim_idx;
    logic                          victim_evict;
    logic [ENTRIES-1:0][TreeW-1:0] touch_mask;
    logic [ENTRIES-1:0][TreeW-1:0] touch_val;

    logic                          accept;
    logic                          touch_en;
    logic [IdxW-1:0]               touch_idx;

    plru_alloc_decode #(
        .ENTRIES (ENTRIES)
    ) u_decode (
        .tree       (tree_q),
        .valid      (valid_q),
        .victim_idx (victim_idx),
        .evict      (victim_evict),
        .touch_mask (touch_mask),
        .touch_val  (touch_val)
    );

    always_comb begin : fsm_comb
        state_d           = state_q;
        alloc_req_ready_o = 1'b0;
        alloc_rsp_valid_o = 1'b0;
        accept            = 1'b0;
        unique case (state_q)
            IDLE: begin
                alloc_req_ready_o = !flush_i;
                accept            = alloc_req_valid_i && !flush_i;
                if (accept) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                alloc_rsp_valid_o = 1'b1;
                if (alloc_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An accepted allocation owns the tree update; a concurrent hit is dropped.
    assign touch_en  = accept || hit_valid_i;
    assign touch_idx = accept ? victim_idx : hit_idx_i;

    always_comb begin : tree_next
        tree_d = tree_q;
        if (flush_i) begin
            tree_d = '0;
        end else if (touch_en) begin
            tree_d = (tree_q & ~touch_mask[touch_idx])
                   | (touch_val[touch_idx] & touch_mask[touch_idx]);
        end
    end

    // Set after clear so an allocation beats a same-index invalidate.
    always_comb begin : valid_next
        valid_d = valid_q;
        if (inval_valid_i) begin
            valid_d[inval_idx_i] = 1'b0;
        end
        if (accept) begin
            valid_d[victim_idx] = 1'b1;
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            tree_q      <= '0;
            valid_q     <= '0;
            rsp_idx_q   <= '0;
            rsp_evict_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tree_q  <= tree_d;
            valid_q <= valid_d;
            if (accept) begin
                rsp_idx_q   <= victim_idx;
                rsp_evict_q <= victim_evict;
            end
        end
    end

    assign alloc_rsp_idx_o   = rsp_idx_q;
    assign alloc_rsp_evict_o = rsp_evict_q;
    assign valid_o           = valid_q;

endmodule
